// File: rtl/affine_transform_if.sv
// Vertex stream, result stream and matrix configuration bundle for
// affine_transform.
//   master : side that produces vertices / config and consumes results
//   slave  : the transform engine itself
// Signals:
//   in_*   : input vertex stream (valid/ready, x/y/z, last) plus per-vertex mode
//   cfg_*  : shadow matrix write port and commit strobe
//   out_*  : result stream (valid/ready, x/y/z, last, per-result saturation)
//   sat_sticky_out : saturation seen since last reset or commit
interface affine_transform_if #(
    parameter int WIDTH = 32
);
    logic             in_valid_in;
    logic             in_ready_out;
    logic [WIDTH-1:0] in_x_in;
    logic [WIDTH-1:0] in_y_in;
    logic [WIDTH-1:0] in_z_in;
    logic             in_last_in;
    logic [1:0]       mode_in;
    logic             cfg_we_in;
    logic [3:0]       cfg_addr_in;
    logic [WIDTH-1:0] cfg_data_in;
    logic             cfg_commit_in;
    logic             out_valid_out;
    logic             out_ready_in;
    logic [WIDTH-1:0] out_x_out;
    logic [WIDTH-1:0] out_y_out;
    logic [WIDTH-1:0] out_z_out;
    logic             out_last_out;
    logic             out_sat_out;
    logic             sat_sticky_out;

    modport master (
        output in_valid_in, in_x_in, in_y_in, in_z_in, in_last_in, mode_in,
               cfg_we_in, cfg_addr_in, cfg_data_in, cfg_commit_in, out_ready_in,
        input  in_ready_out, out_valid_out, out_x_out, out_y_out, out_z_out,
               out_last_out, out_sat_out, sat_sticky_out
    );

    modport slave (
        input  in_valid_in, in_x_in, in_y_in, in_z_in, in_last_in, mode_in,
               cfg_we_in, cfg_addr_in, cfg_data_in, cfg_commit_in, out_ready_in,
        output in_ready_out, out_valid_out, out_x_out, out_y_out, out_z_out,
               out_last_out, out_sat_out, sat_sticky_out
    );
endinterface

// File: rtl/affine_transform.sv
// Pipelined 3x4 affine vertex transform (implicit bottom row 0 0 0 1).
// Vertices stream in over bus.in_*, are multiplied by a double-buffered
// matrix and leave rounded (half-up) and saturated over bus.out_* three
// cycles later. Matrix entries are written to a shadow copy through
// bus.cfg_* and copied to the active copy on bus.cfg_commit_in.
// Ports:
//   clk_in : clock, rising edge
//   rst_in : asynchronous active-low reset
//   bus    : affine_transform_if slave modport (vertex, result, config)

// One matrix row: S1 products + translation, S2 sum, S3 round/saturate.
module affine_row #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  en_in,
    input  logic [3:0][WIDTH-1:0] m_in,   // row entries, [3] is translation
    input  logic [2:0][WIDTH-1:0] v_in,   // {z, y, x}
    output logic [WIDTH-1:0]      res_out,
    output logic                  sat_nxt_out  // saturation of the value entering S3
);
    localparam int W2 = 2 * WIDTH;
    localparam int WS = W2 + 2;
    localparam logic signed [WS-1:0] HALF = WS'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [WS-1:0] MAXV = (WS'(1) <<< (WIDTH - 1)) - WS'(1);
    localparam logic signed [WS-1:0] MINV = -(WS'(1) <<< (WIDTH - 1));

    logic [2:0][W2-1:0]   prod_d, prod_q;
    logic [W2-1:0]        tr_d, tr_q;
    logic signed [WS-1:0] sum_d, sum_q;
    logic [WIDTH-1:0]     res_d, res_q;
    logic signed [WS-1:0] rnd;
    logic                 sat;

    always_comb begin
        prod_d = prod_q;
        tr_d   = tr_q;
        sum_d  = sum_q;
        res_d  = res_q;
        // Round half-up then clamp; widths leave headroom so nothing wraps.
        rnd = (sum_q + HALF) >>> FRAC_BITS;
        sat = 1'b0;
        if (en_in) begin
            for (int c = 0; c < 3; c++)
                prod_d[c] = W2'($signed(m_in[c])) * W2'($signed(v_in[c]));
            tr_d  = W2'($signed(m_in[3])) <<< FRAC_BITS;
            sum_d = WS'($signed(prod_q[0])) + WS'($signed(prod_q[1]))
                  + WS'($signed(prod_q[2])) + WS'($signed(tr_q));
            if (rnd > MAXV) begin
                res_d = {1'b0, {(WIDTH-1){1'b1}}};
                sat   = 1'b1;
            end else if (rnd < MINV) begin
                res_d = {1'b1, {(WIDTH-1){1'b0}}};
                sat   = 1'b1;
            end else begin
                res_d = rnd[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prod_q <= '0;
            tr_q   <= '0;
            sum_q  <= '0;
            res_q  <= '0;
        end else begin
            prod_q <= prod_d;
            tr_q   <= tr_d;
            sum_q  <= sum_d;
            res_q  <= res_d;
        end
    end

    assign res_out     = res_q;
    assign sat_nxt_out = sat;
endmodule

module affine_transform #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input logic               clk_in,
    input logic               rst_in,
    affine_transform_if.slave bus
);
    localparam int NUM_ROWS = 3;
    localparam int STAGES   = 3;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC_BITS;

    typedef logic [NUM_ROWS-1:0][3:0][WIDTH-1:0] mat_t;

    function automatic mat_t ident_mat();
        mat_t m;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = (r == c) ? ONE : '0;
        return m;
    endfunction

    localparam mat_t IDENT = ident_mat();

    mat_t                          shd_d, shd_q, act_d, act_q, eff;
    logic [STAGES-1:0]             vld_d, vld_q, last_d, last_q;
    logic [STAGES:0]               vld_pipe, last_pipe;
    logic                          sat_d, sat_q, sticky_d, sticky_q;
    logic                          adv, accept;
    logic [NUM_ROWS-1:0][WIDTH-1:0] row_res;
    logic [NUM_ROWS-1:0]           row_sat;
    logic [NUM_ROWS-1:0][WIDTH-1:0] vec;

    // Whole pipeline moves together; bubbles hold too when stalled.
    assign adv       = !vld_q[STAGES-1] || bus.out_ready_in;
    assign accept    = bus.in_valid_in && bus.in_ready_out;
    assign vld_pipe  = {vld_q, accept};
    assign last_pipe = {last_q, bus.in_last_in};
    assign vec       = {bus.in_z_in, bus.in_y_in, bus.in_x_in};

    // Matrix seen by the vertex being accepted. Passthrough is identity with
    // zero translation: round-half-up of x<<FRAC_BITS returns x exactly and
    // can never clamp, so it needs no separate datapath.
    always_comb begin
        eff = act_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (bus.mode_in == 2'd0 || bus.mode_in == 2'd1)
                for (int c = 0; c < 3; c++)
                    eff[r][c] = (r == c) ? ONE : '0;
            if (bus.mode_in == 2'd0)
                eff[r][3] = '0;
        end
    end

    // Shadow write lands before the commit copy, so a same-cycle write is
    // part of the committed matrix. Row 3 addresses are dropped.
    always_comb begin
        shd_d = shd_q;
        if (bus.cfg_we_in && bus.cfg_addr_in[3:2] != 2'b11)
            shd_d[bus.cfg_addr_in[3:2]][bus.cfg_addr_in[1:0]] = bus.cfg_data_in;
        act_d = bus.cfg_commit_in ? shd_d : act_q;
    end

    always_comb begin
        vld_d    = vld_q;
        last_d   = last_q;
        sat_d    = sat_q;
        sticky_d = bus.cfg_commit_in ? 1'b0 : sticky_q;
        if (adv) begin
            vld_d  = vld_pipe[STAGES-1:0];
            last_d = last_pipe[STAGES-1:0];
            sat_d  = vld_pipe[STAGES-1] && (|row_sat);
            if (sat_d)
                sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shd_q    <= IDENT;
            act_q    <= IDENT;
            vld_q    <= '0;
            last_q   <= '0;
            sat_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            shd_q    <= shd_d;
            act_q    <= act_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
            sat_q    <= sat_d;
            sticky_q <= sticky_d;
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        affine_row #(
            .WIDTH     (WIDTH),
            .FRAC_BITS (FRAC_BITS)
        ) u_row (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .en_in       (adv),
            .m_in        (eff[r]),
            .v_in        (vec),
            .res_out     (row_res[r]),
            .sat_nxt_out (row_sat[r])
        );
    end

    assign bus.in_ready_out   = rst_in && adv;
    assign bus.out_valid_out  = vld_pipe[STAGES];
    assign bus.out_last_out   = last_pipe[STAGES];
    assign bus.out_sat_out    = sat_q;
    assign bus.sat_sticky_out = sticky_q;
    assign bus.out_x_out      = row_res[0];
    assign bus.out_y_out      = row_res[1];
    assign bus.out_z_out      = row_res[2];
endmodule

// File: tb/tb_affine_transform.sv
module tb_affine_transform;
    localparam logic [31:0] ONE = 32'h0001_0000;

    typedef struct {
        logic [31:0] x, y, z;
        logic        last, sat;
    } res_t;

    logic clk, rst_n;
    int   checks = 0, failures = 0, delivered = 0;

    res_t              exp_q[$];
    res_t              obs[$];
    logic signed [31:0] m_act[3][4];
    logic signed [31:0] m_shd[3][4];

    affine_transform_if #(.WIDTH(32)) bus ();

    affine_transform #(.WIDTH(32), .FRAC_BITS(16)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference: plain wide-integer matrix arithmetic from the block's rules.
    function automatic res_t model(input logic [31:0] x, y, z, input logic [1:0] mode,
                                   input logic last);
        res_t e;
        logic signed [31:0] v[3];
        logic signed [31:0] m[3][4];
        logic signed [69:0] s;
        logic [31:0] r_out[3];
        v = '{x, y, z};
        e.last = last;
        e.sat  = 1'b0;
        if (mode == 2'd0) begin
            e.x = x; e.y = y; e.z = z;
            return e;
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = (mode == 2'd1 && c < 3) ? ((r == c) ? ONE : 32'sd0) : m_act[r][c];
        for (int r = 0; r < 3; r++) begin
            s = 70'(m[r][0]) * 70'(v[0]) + 70'(m[r][1]) * 70'(v[1])
              + 70'(m[r][2]) * 70'(v[2]) + (70'(m[r][3]) <<< 16);
            s = (s + 70'sd32768) >>> 16;
            if (s > 70'sd2147483647) begin
                r_out[r] = 32'h7FFF_FFFF; e.sat = 1'b1;
            end else if (s < -70'sd2147483648) begin
                r_out[r] = 32'h8000_0000; e.sat = 1'b1;
            end else begin
                r_out[r] = s[31:0];
            end
        end
        e.x = r_out[0]; e.y = r_out[1]; e.z = r_out[2];
        return e;
    endfunction

    task automatic mat_reset();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                m_act[r][c] = (r == c) ? ONE : 32'sd0;
                m_shd[r][c] = (r == c) ? ONE : 32'sd0;
            end
    endtask

    // Model + scoreboard: everything here acts on what the next rising edge will do.
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            exp_q.delete();
            mat_reset();
        end else begin
            if (bus.out_valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_out: got valid x=%h with nothing expected", bus.out_x_out);
                end else if (bus.out_ready_in) begin
                    e = exp_q.pop_front();
                    checks++;
                    obs.push_back('{bus.out_x_out, bus.out_y_out, bus.out_z_out,
                                    bus.out_last_out, bus.out_sat_out});
                    delivered++;
                    if (bus.out_x_out !== e.x || bus.out_y_out !== e.y || bus.out_z_out !== e.z ||
                        bus.out_last_out !== e.last || bus.out_sat_out !== e.sat) begin
                        failures++;
                        $display("FAIL result: got %h %h %h last=%b sat=%b expected %h %h %h last=%b sat=%b",
                                 bus.out_x_out, bus.out_y_out, bus.out_z_out, bus.out_last_out,
                                 bus.out_sat_out, e.x, e.y, e.z, e.last, e.sat);
                    end
                end
            end
            if (bus.in_valid_in && bus.in_ready_out)
                exp_q.push_back(model(bus.in_x_in, bus.in_y_in, bus.in_z_in, bus.mode_in,
                                      bus.in_last_in));
            if (bus.cfg_we_in && bus.cfg_addr_in < 4'd12)
                m_shd[bus.cfg_addr_in / 4][bus.cfg_addr_in % 4] = bus.cfg_data_in;
            if (bus.cfg_commit_in)
                m_act = m_shd;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic res_t get_obs(input int idx);
        res_t r;
        if (idx < obs.size()) r = obs[idx];
        return r;   // unset entries stay X and fail any literal compare
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        bus.cfg_we_in = 1'b1; bus.cfg_addr_in = a; bus.cfg_data_in = d;
        tick();
        bus.cfg_we_in = 1'b0;
    endtask

    task automatic commit();
        bus.cfg_commit_in = 1'b1;
        tick();
        bus.cfg_commit_in = 1'b0;
    endtask

    task automatic set_diag(input logic [31:0] d);
        cfg_write(4'd0, d); cfg_write(4'd5, d); cfg_write(4'd10, d);
    endtask

    task automatic send(input logic [31:0] x, y, z, input logic [1:0] mode, input logic last);
        int n;
        n = 0;
        bus.in_valid_in = 1'b1; bus.in_x_in = x; bus.in_y_in = y; bus.in_z_in = z;
        bus.mode_in = mode; bus.in_last_in = last;
        @(negedge clk);
        while (!bus.in_ready_out && n < 100) begin
            @(negedge clk); n++;
        end
        if (!bus.in_ready_out) begin
            checks++; failures++;
            $display("FAIL send_timeout: in_ready stayed %b required 1", bus.in_ready_out);
        end
        tick();
        bus.in_valid_in = 1'b0; bus.in_last_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d results pending required 0", exp_q.size());
        end
        tick();
    endtask

    initial begin
        int base, d0;
        rst_n = 1'b0;
        bus.in_valid_in = 0; bus.in_x_in = 0; bus.in_y_in = 0; bus.in_z_in = 0;
        bus.in_last_in = 0; bus.mode_in = 0; bus.cfg_we_in = 0; bus.cfg_addr_in = 0;
        bus.cfg_data_in = 0; bus.cfg_commit_in = 0; bus.out_ready_in = 1'b1;
        repeat (3) tick();
        chk("ready_in_reset", {31'b0, bus.in_ready_out}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("reset_valid", {31'b0, bus.out_valid_out}, 32'd0);
        chk("reset_x", bus.out_x_out, 32'd0);
        chk("reset_sticky", {31'b0, bus.sat_sticky_out}, 32'd0);
        chk("reset_ready", {31'b0, bus.in_ready_out}, 32'd1);

        // Translate-only with exact latency
        cfg_write(4'd3, 32'h000A_0000);
        cfg_write(4'd11, 32'hFFFB_0000);
        commit();
        send(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 2'd1, 1'b0);
        tick();
        chk("lat_not_yet", {31'b0, bus.out_valid_out}, 32'd0);
        tick();
        chk("lat_valid", {31'b0, bus.out_valid_out}, 32'd1);
        chk("trans_x", bus.out_x_out, 32'h000B_0000);
        chk("trans_y", bus.out_y_out, 32'h0002_0000);
        chk("trans_z", bus.out_z_out, 32'hFFFE_0000);
        chk("trans_sat", {31'b0, bus.out_sat_out}, 32'd0);
        drain();

        // Scale and half-up rounding; passthrough untouched
        cfg_write(4'd3, 32'd0); cfg_write(4'd11, 32'd0);
        set_diag(32'h0002_0000); commit();
        base = obs.size();
        send(32'h1, 32'h0, 32'h0, 2'd2, 1'b0);
        drain();
        chk("scale2_x", get_obs(base).x, 32'h2);
        set_diag(32'h0000_8000); commit();
        send(32'h1, 32'h0, 32'h0, 2'd3, 1'b0);
        send(32'h0001_2345, 32'hFFFF_8001, 32'h7FFF_FFFF, 2'd0, 1'b0);
        drain();
        chk("half_round_x", get_obs(base + 1).x, 32'h1);
        chk("pass_y", get_obs(base + 2).y, 32'hFFFF_8001);
        chk("pass_z", get_obs(base + 2).z, 32'h7FFF_FFFF);

        // Saturation both directions, sticky cleared by commit
        set_diag(32'h0002_0000); commit();
        base = obs.size();
        send(32'h7FFF_0000, 32'h0, 32'h0, 2'd2, 1'b0);
        send(32'h8000_0000, 32'h0, 32'h0, 2'd2, 1'b0);
        drain();
        chk("sat_hi_x", get_obs(base).x, 32'h7FFF_FFFF);
        chk("sat_hi_flag", {31'b0, get_obs(base).sat}, 32'd1);
        chk("sat_lo_x", get_obs(base + 1).x, 32'h8000_0000);
        chk("sat_lo_flag", {31'b0, get_obs(base + 1).sat}, 32'd1);
        chk("sticky_set", {31'b0, bus.sat_sticky_out}, 32'd1);
        commit();
        chk("sticky_clr", {31'b0, bus.sat_sticky_out}, 32'd0);

        // Backpressure: six back-to-back vertices, downstream stalls mid-stream
        base = obs.size();
        d0 = delivered;
        fork
            for (int i = 1; i <= 6; i++)
                send(32'(i) << 16, 32'(i), 32'hFFFF_0000 - 32'(i), 2'd2, i == 6);
            begin
                repeat (3) tick();
                bus.out_ready_in = 1'b0;
                repeat (5) tick();
                bus.out_ready_in = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(delivered - d0), 32'd6);
        chk("bp_first_x", get_obs(base).x, 32'h0002_0000);
        chk("bp_last_flag", {31'b0, get_obs(base + 5).last}, 32'd1);
        chk("bp_5th_nolast", {31'b0, get_obs(base + 4).last}, 32'd0);

        // Commit in A's acceptance cycle: A old matrix, B/C new
        set_diag(ONE); commit();
        cfg_write(4'd3, ONE);
        base = obs.size();
        bus.cfg_commit_in = 1'b1;
        send(ONE, 32'h0, 32'h0, 2'd1, 1'b0);
        bus.cfg_commit_in = 1'b0;
        send(ONE, 32'h0, 32'h0, 2'd1, 1'b0);
        send(ONE, 32'h0, 32'h0, 2'd1, 1'b1);
        drain();
        chk("commit_A", get_obs(base).x, 32'h0001_0000);
        chk("commit_B", get_obs(base + 1).x, 32'h0002_0000);
        chk("commit_C", get_obs(base + 2).x, 32'h0002_0000);

        // Reset with three vertices in flight
        send(32'h0005_0000, 32'h0, 32'h0, 2'd2, 1'b0);
        send(32'h0006_0000, 32'h0, 32'h0, 2'd2, 1'b0);
        send(32'h0007_0000, 32'h0, 32'h0, 2'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_valid_now", {31'b0, bus.out_valid_out}, 32'd0);
        chk("rst_ready_now", {31'b0, bus.in_ready_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("rst_no_stale", {31'b0, bus.out_valid_out}, 32'd0);
        base = obs.size();
        send(32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 2'd2, 1'b0);
        drain();
        chk("rst_ident_x", get_obs(base).x, 32'h0003_0000);
        chk("rst_ident_y", get_obs(base).y, 32'h0004_0000);
        chk("rst_ident_z", get_obs(base).z, 32'h0005_0000);
        chk("end_pending", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/affine_transform.md
# affine_transform

Parametrised, pipelined 4x4 affine vertex transform for the 3D geometry path. It replaces the single fixed translation stage with one configurable engine. Each vertex (x, y, z) is streamed in with a valid/ready handshake and multiplied by a double-buffered, register-loaded 3x4 matrix; the implicit bottom row is 0 0 0 1. Results are rounded and saturated in signed fixed point. The block sits between the vertex fetch and the projection stage.

## Interface
- WIDTH, 32, signed fixed-point word width of coordinates and matrix entries
- FRAC_BITS, 16, fractional bits (Q(WIDTH-FRAC_BITS).FRAC_BITS); 1 <= FRAC_BITS < WIDTH

- clk_in  input  1  single clock, all logic rising-edge
- rst_in  input  1  reset, asynchronous and active-low
- in_valid_in  input  1  input vertex valid
- in_ready_out  output  1  block accepts vertex this cycle
- in_x_in, in_y_in, in_z_in  input  WIDTH each  vertex coordinates, signed
- in_last_in  input  1  end-of-mesh marker, carried through unchanged
- mode_in  input  2  0 passthrough, 1 translate-only, 2 full affine, 3 treated as 2; sampled per vertex at acceptance
- cfg_we_in  input  1  shadow matrix write strobe
- cfg_addr_in  input  4  entry index row*4+col; rows 0..2 only
- cfg_data_in  input  WIDTH  entry value
- cfg_commit_in  input  1  copy shadow matrix to active matrix
- out_valid_out  output  1  result valid
- out_ready_in  input  1  downstream accepts result
- out_x_out, out_y_out, out_z_out  output  WIDTH each  transformed coordinates
- out_last_out  output  1  delayed in_last_in
- out_sat_out  output  1  at least one coordinate of this result saturated
- sat_sticky_out  output  1  sticky saturation flag since last reset/commit

## Operation
- Matrix M[r][c], r in 0..2, c in 0..3. Column 3 is translation. Result_r = M[r][0]*x + M[r][1]*y + M[r][2]*z + (M[r][3] << FRAC_BITS), then rescaled.
- Mode 0: output = input, unrounded and never saturated. Mode 1: the 3x3 part is forced to identity and only column 3 is applied. Mode 2/3: full matrix.
- Shadow/active double buffer. cfg_we_in writes the shadow copy only. Addresses 3, 7 and 11 are translation entries; addresses 12..15 are ignored.
- cfg_commit_in copies shadow to active at the clock edge. A write in the same cycle as a commit is included in the committed matrix. Commit clears sat_sticky_out.
- Each vertex captures the active matrix and mode at acceptance. In-flight vertices are never affected by later writes or commits.
- Arithmetic:
  - Products are 2*WIDTH signed; the sum is held at 2*WIDTH+2 bits.
  - Round half-up: add 1 << (FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Any clamp sets out_sat_out for that vertex and sets sat_sticky_out.
- Reset values:
  - Active and shadow matrices = identity: diagonal 1 << FRAC_BITS, all else 0.
  - out_valid_out, out_last_out, out_sat_out, sat_sticky_out = 0.
  - out_x/y/z_out = 0. Pipeline valids = 0.

## Timing
- Three-stage pipeline:
  - S1 registers the 9 products plus the translation terms.
  - S2 registers the sums.
  - S3 registers the rounded, saturated output.
- Latency is 3 cycles from acceptance to out_valid_out, with no stall. Throughput is 1 vertex/cycle.
- Global advance enable = !out_valid_out || out_ready_in. in_ready_out equals this enable (combinational), and is 0 while rst_in is low.
- Acceptance occurs when in_valid_in && in_ready_out. When enable is 0, all stages hold, including bubbles.
- Output stability: out_* is held stable while out_valid_out && !out_ready_in.
- Asserting rst_in at any time immediately clears all pipeline valids and outputs. In-flight vertices are discarded, and both matrices return to identity.
- Simultaneous cfg_commit_in and acceptance: that vertex uses the pre-commit matrix.

## Test plan
- Translate: mode 1, M[0][3]=10.0, M[2][3]=-5.0, input (1.0, 2.0, 3.0), i.e. 0x00010000, 0x00020000, 0x00030000 -> output (11.0, 2.0, -2.0) 3 cycles later, out_sat_out=0.
- Scale and round: mode 2, diagonal 2.0, input x=0x00000001 -> 0x00000002. Diagonal 0.5, x=0x00000001 -> 0x00000001 (half-up rounding).
- Saturate: diagonal 2.0, x=0x7FFF0000 -> 0x7FFFFFFF with out_sat_out=1 and sat_sticky_out=1. x=0x80000000 -> 0x80000000 (clamp). Then commit -> sticky clears.
- Backpressure: stream 6 vertices with out_ready_in low for cycles 4..8 -> all 6 vertices delivered in order, none dropped or duplicated, in_last_out on the 6th only.
- Commit mid-stream: vertices A, B, C on consecutive cycles, commit of a new translation in the A acceptance cycle -> A uses the old matrix, B and C use the new one.
- Reset mid-stream: rst_in low for 1 cycle with 3 vertices in flight -> out_valid_out=0 immediately, no stale output after release, matrix back to identity (input equals output in mode 2).
